udp_status_sender: RTL



---
 rtl/udp_status_pkg.sv | 17 +
 rtl/heartbeat_timer.sv | 15 +
 rtl/udp_status_sender.sv | 93 +++++++++
 3 files changed

// File: rtl/udp_status_pkg.sv
// udp_status_pkg: shared constants and types for the UDP status datagram sender.
package udp_status_pkg;
  localparam int PAYLOAD_LEN = 16;
  localparam logic [7:0] TYPE_ACK = 8'h01;
  localparam logic [7:0] TYPE_HEARTBEAT = 8'h02;
  localparam logic [15:0] DEFAULT_MAGIC = 16'h4C43;
  localparam logic [3:0] OFF_MAGIC = 4'd0;
  localparam logic [3:0] OFF_TYPE = 4'd2;
  localparam logic [3:0] OFF_BUTTON = 4'd3;
  localparam logic [3:0] OFF_SEQ = 4'd4;
  localparam logic [3:0] OFF_FRAME = 4'd6;
  localparam logic [3:0] OFF_ERR = 4'd10;
  localparam logic [3:0] OFF_MASK = 4'd12;
  localparam logic [3:0] OFF_PAD = 4'd14;
  localparam logic [3:0] OFF_CSUM = 4'd15;
  typedef enum logic {IDLE, SEND} state_t;
endpackage

// File: rtl/heartbeat_timer.sv
// heartbeat_timer: free-running 0..HEARTBEAT_CYCLES-1 counter; tick on terminal count, never when 0.
module heartbeat_timer #(
  parameter int unsigned HEARTBEAT_CYCLES = 125000000
) (
  input  logic clock,
  input  logic resetn,
  output logic tick
);
  localparam int W = HEARTBEAT_CYCLES > 1 ? $clog2(HEARTBEAT_CYCLES) : 1;
  logic [W-1:0] cnt;
  assign tick = HEARTBEAT_CYCLES != 0 && cnt == W'(HEARTBEAT_CYCLES - 1);
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) cnt <= '0;
    else cnt <= (HEARTBEAT_CYCLES == 0 || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/udp_status_sender.sv
// udp_status_sender: builds 16-byte ack/heartbeat status datagrams and streams them into udp0_sink.
module udp_status_sender
  import udp_status_pkg::*;
#(
  parameter int unsigned HEARTBEAT_CYCLES = 125000000,
  parameter logic [15:0] MAGIC = DEFAULT_MAGIC
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       ack_req,
  input  logic       rx_error,
  input  logic       button,
  input  logic [8:0] panel_mask,
  output logic       udp0_sink_valid,
  output logic       udp0_sink_last,
  output logic [7:0] udp0_sink_data,
  input  logic       udp0_sink_ready,
  output logic       busy
);
  state_t state;
  logic tick, ack_pending, hb_pending, accept;
  logic [31:0] frame_cnt;
  logic [15:0] err_cnt, seq;
  logic [3:0] byte_idx;
  logic [PAYLOAD_LEN-1:0][7:0] live, snap;
  heartbeat_timer #(.HEARTBEAT_CYCLES(HEARTBEAT_CYCLES)) u_timer (
    .clock(clock),
    .resetn(resetn),
    .tick(tick)
  );
  assign accept = state == SEND && udp0_sink_ready;
  always_comb begin
    live = '0;
    live[OFF_MAGIC] = MAGIC[15:8];
    live[OFF_MAGIC+4'd1] = MAGIC[7:0];
    live[OFF_TYPE] = ack_pending ? TYPE_ACK : TYPE_HEARTBEAT;
    live[OFF_BUTTON] = {7'b0, button};
    live[OFF_SEQ] = seq[15:8];
    live[OFF_SEQ+4'd1] = seq[7:0];
    live[OFF_FRAME] = frame_cnt[31:24];
    live[OFF_FRAME+4'd1] = frame_cnt[23:16];
    live[OFF_FRAME+4'd2] = frame_cnt[15:8];
    live[OFF_FRAME+4'd3] = frame_cnt[7:0];
    live[OFF_ERR] = err_cnt[15:8];
    live[OFF_ERR+4'd1] = err_cnt[7:0];
    live[OFF_MASK] = {7'b0, panel_mask[8]};
    live[OFF_MASK+4'd1] = panel_mask[7:0];
    live[OFF_PAD] = 8'h00;
    for (int i = 0; i < int'(OFF_CSUM); i++) live[OFF_CSUM] = live[OFF_CSUM] ^ live[4'(i)];
  end
  // Pending flags: a request arriving on the very cycle IDLE consumes the flag keeps it set.
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      state <= IDLE;
      ack_pending <= 1'b0;
      hb_pending <= 1'b0;
      frame_cnt <= '0;
      err_cnt <= '0;
      seq <= '0;
      byte_idx <= '0;
      snap <= '0;
      udp0_sink_valid <= 1'b0;
      udp0_sink_last <= 1'b0;
      udp0_sink_data <= '0;
      busy <= 1'b0;
    end else begin
      frame_cnt <= frame_cnt + 32'(ack_req);
      if (rx_error && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
      ack_pending <= ack_req || (ack_pending && state != IDLE);
      hb_pending <= tick || (hb_pending && (state != IDLE || ack_pending));
      if (state == IDLE && (ack_pending || hb_pending)) begin
        state <= SEND;
        busy <= 1'b1;
        snap <= live;
        byte_idx <= '0;
        udp0_sink_valid <= 1'b1;
        udp0_sink_data <= live[0];
      end else if (accept) begin
        if (byte_idx == OFF_CSUM) begin
          state <= IDLE;
          busy <= 1'b0;
          udp0_sink_valid <= 1'b0;
          udp0_sink_last <= 1'b0;
          udp0_sink_data <= '0;
          seq <= seq + 16'd1;
        end else begin
          byte_idx <= byte_idx + 4'd1;
          udp0_sink_data <= snap[byte_idx+4'd1];
          udp0_sink_last <= byte_idx == OFF_CSUM - 4'd1;
        end
      end
    end
endmodule
